// File: rtl/snes_state_logger.sv
// Moves the snooper's controller word into clk, timestamps it, optionally filters repeats, and queues it for a reader.
// Define SNES_LOGGER_DELTA_EN for a time field holding frames elapsed since the last pushed entry.
module snes_state_logger #(
   parameter int DEPTH       = 16,
   parameter bit CHANGE_ONLY = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [15:0]             snes_state,
   input  logic                    snes_valid,
   input  logic                    out_ready,
   input  logic                    clear_overflow,
   output logic                    out_valid,
   output logic [31:0]             out_data,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [15:0] tstamp;
      logic [15:0] state;
   } entry_t;

   logic          s1, s2, s3, frame_evt, dec_vld, have_prev;
   logic [15:0]   cap_state, cap_time, prev_state;
   logic          push_req, pop, wr_en, drop;
   logic [AW-1:0] wr_ptr, rd_ptr;
   entry_t        mem [DEPTH];
   entry_t        wr_entry;

   // snes_valid is asynchronous; snes_state is held stable by contract and sampled raw
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= snes_valid;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign frame_evt = s2 & ~s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_state <= '0;
         dec_vld   <= 1'b0;
      end else begin
         dec_vld <= frame_evt;
         if (frame_evt) cap_state <= snes_state;
      end
   end

`ifdef SNES_LOGGER_DELTA_EN
   logic [15:0] since_cnt, since_inc;

   assign since_inc = (since_cnt == 16'hFFFF) ? since_cnt : since_cnt + 16'd1;

   // since_cnt counts frames after the last successful push, dropped ones included
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         since_cnt <= '0;
         cap_time  <= '0;
      end else begin
         if (frame_evt) cap_time <= have_prev ? since_inc : 16'd0;
         if (wr_en)          since_cnt <= '0;
         else if (frame_evt) since_cnt <= since_inc;
      end
   end
`else
   logic [15:0] frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         cap_time  <= '0;
      end else if (frame_evt) begin
         cap_time  <= frame_cnt;
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

   always_comb begin
      push_req = dec_vld & (!CHANGE_ONLY | !have_prev | (cap_state != prev_state));
      pop      = out_valid & out_ready;
      wr_en    = push_req & ((level != FULL_LVL) | pop);
      drop     = push_req & ~wr_en;
      wr_entry = '{tstamp: cap_time, state: cap_state};
   end

   assign out_valid = (level != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_entry;
   end

   // pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // a dropped change keeps prev_state stale so the next frame re-detects it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_state <= '0;
         have_prev  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) begin
            prev_state <= cap_state;
            have_prev  <= 1'b1;
         end
         if (drop)                overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end
endmodule

// File: doc/snes_state_logger.md
Name: snes_state_logger

Overview:
- Downstream consumer of the snooper's captured controller word (state[15:0]) and its valid flag.
- Moves the word into the system clock domain and timestamps it with a 16-bit frame count.
- Optionally filters out unchanged frames, then buffers entries in a FIFO for a ready/valid reader (UART/host bridge).
- Produces a compact log of button changes instead of a raw level on pins.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CHANGE_ONLY, 1, 1 = push only when the word differs from the last pushed word; 0 = push every frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- snes_state  input  16  snooper captured word; held stable while snes_valid is high
- snes_valid  input  1  snooper valid; asynchronous to clk, high >= 3 clk periods per frame
- out_ready  input  1  reader accepts the head entry
- clear_overflow  input  1  single-cycle pulse; clears overflow
- out_valid  output  1  FIFO head entry available
- out_data  output  32  {time[15:0], state[15:0]}
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky; an entry was dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. All flops clear on rst assertion, independent of clk.
- Reset values: out_valid=0, out_data=0, level=0, overflow=0, frame_cnt=0, prev_state=0, have_prev=0, sync flops=0.
- Reset mid-operation: FIFO contents are discarded, pointers return to 0, and any in-flight capture is abandoned.
- Synchronizer: snes_valid passes through two flops (s1, s2) plus a history flop s3.
  - Frame event = s2 & ~s3.
  - If snes_valid is first sampled high at edge N, the event is high in the cycle after edge N+1.
  - snes_state is registered into cap_state at edge N+2 without synchronization; stability is guaranteed by the input contract.
- Decision cycle, the cycle after edge N+2:
  - push = !CHANGE_ONLY | !have_prev | (cap_state != prev_state).
  - Entry = {time, cap_state}, where time = frame_cnt value for this frame.
  - frame_cnt increments (wrapping 0xFFFF->0) on every frame event, whether or not the frame is pushed. The first frame after reset has time=0.
- FIFO write at edge N+3.
  - The write succeeds if level < DEPTH, or level == DEPTH with a pop in the same cycle.
  - On success: prev_state <= cap_state, have_prev <= 1.
  - On drop (full, no pop): overflow <= 1, prev_state and have_prev unchanged, so the change is re-detected on the next frame.
- Output interface: first-word fall-through.
  - out_valid = (level != 0). out_data is the head entry.
  - Pop occurs when out_valid & out_ready at a clk edge.
  - out_valid rises after edge N+3 when the FIFO was previously empty.
  - out_data is stable while out_valid & !out_ready.
- Simultaneous events:
  - Push and pop in the same cycle leave level unchanged.
  - Pop from empty is ignored.
  - clear_overflow and a drop in the same cycle leave overflow = 1 (set wins).
- Pointers: wrap modulo DEPTH. level saturates by construction at DEPTH.
- Back-to-back frames closer than 4 clk cycles are out of contract. The block still never corrupts FIFO pointers.

Optional Feature:
- Macro: SNES_LOGGER_DELTA_EN.
- Defined: time field = frames elapsed since the previous successfully pushed entry, saturating at 0xFFFF. The first entry after reset reports 0. The counter resets to 0 on each successful push and counts dropped frames.
- Undefined: time field = absolute frame_cnt, wrapping, as described in Behaviour. Port list is identical in both builds.

Test Plan:
- Reset, then three frames with state 0x0F00, 0x0F00, 0x0080, CHANGE_ONLY=1, out_ready=1 -> two entries, 0x00000F00 then 0x00020080; overflow=0.
- CHANGE_ONLY=0, five identical frames of 0x1234 -> five entries with time 0..4, data 0x00001234..0x00041234.
- DEPTH=4, out_ready=0, six changing frames -> level=4, overflow=1, head = first frame.
  - Then pulse clear_overflow -> overflow=0.
  - Then drain -> four entries in order.
- Full FIFO with out_ready=1 exactly on the write cycle of a new frame -> no drop, level stays 4, overflow stays 0.
- rst asserted between the frame event and the FIFO write -> no entry appears; the next frame logs time=0.
- SNES_LOGGER_DELTA_EN defined, frames 0xAAAA, 0xAAAA, 0xAAAA, 0x5555 -> entries 0x0000AAAA, 0x00035555.
